score_bcd_counter: RTL and testbench



---
 rtl/score_pkg.sv | 15 +
 rtl/bcd_digit_add.sv | 21 ++
 rtl/score_bcd_counter.sv | 132 +++++++++++++
 tb/tb_score_bcd_counter.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/score_pkg.sv
// Shared types and constants for the score counter: BCD digit type, FSM
// state encoding and the seg7 decoder input width.
package score_pkg;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        OVER
    } state_t;

    localparam int DIGIT_W = 5;

endpackage

// File: rtl/bcd_digit_add.sv
// Single BCD digit adder. The addend may be as large as 10 (tick plus a
// 9-point coin), which still produces at most one carry from a valid digit.
module bcd_digit_add
    import score_pkg::*;
(
    input  bcd_digit_t digit,
    input  bcd_digit_t addend,
    input  logic       carry_in,
    output bcd_digit_t sum,
    output logic       carry_out
);

    logic [4:0] raw;

    always_comb begin
        raw       = 5'(digit) + 5'(addend) + 5'(carry_in);
        carry_out = (raw >= 5'd10);
        sum       = carry_out ? 4'(raw - 5'd10) : raw[3:0];
    end

endmodule

// File: rtl/score_bcd_counter.sv
// Running/high score keeper in packed BCD with start/tick/coin/game_over
// sequencing, saturation at all 9s, and a display mux with leading-zero blanking.
//
//   state | meaning
//   IDLE  | after reset, waiting for the first start
//   RUN   | game in progress, tick/coin add to the score
//   OVER  | run ended, score frozen until the next start
module score_bcd_counter
    import score_pkg::*;
#(
    parameter int DIGITS     = 6,
    parameter int COIN_VALUE = 5
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic                      tick,
    input  logic                      coin,
    input  logic                      game_over,
    input  logic                      show_high,
    output logic [DIGITS*DIGIT_W-1:0] digits,
    output logic [DIGITS-1:0]         blank,
    output logic                      running,
    output logic                      saturated,
    output logic                      new_high
);

    localparam logic [4*DIGITS-1:0] ALL_NINES = {DIGITS{4'h9}};

    state_t              state, state_nxt;
    logic [4*DIGITS-1:0] score, score_nxt;
    logic [4*DIGITS-1:0] high, high_nxt;
    logic                new_high_nxt;
    logic [4*DIGITS-1:0] sum_vec;
    logic [DIGITS:0]     carry;
    bcd_digit_t          addend;
    logic [4*DIGITS-1:0] shown;

    always_comb begin
        addend = 4'd0;
        if (tick && coin)
            addend = 4'(1 + COIN_VALUE);
        else if (coin)
            addend = 4'(COIN_VALUE);
        else if (tick)
            addend = 4'd1;
    end

    assign carry[0] = 1'b0;

    for (genvar g = 0; g < DIGITS; g++) begin : g_add
        bcd_digit_add u_add (
            .digit     (score[4*g +: 4]),
            .addend    ((g == 0) ? addend : 4'd0),
            .carry_in  (carry[g]),
            .sum       (sum_vec[4*g +: 4]),
            .carry_out (carry[g+1])
        );
    end

    always_comb begin
        state_nxt    = state;
        score_nxt    = score;
        high_nxt     = high;
        new_high_nxt = new_high;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                    score_nxt = '0;
                end
            end
            RUN: begin
                if (start) begin
                    score_nxt = '0;
                end else if (game_over) begin
                    state_nxt = OVER;
                    // packed BCD orders the same as plain unsigned binary
                    if (score > high) begin
                        high_nxt     = score;
                        new_high_nxt = 1'b1;
                    end
                end else if (carry[DIGITS]) begin
                    score_nxt = ALL_NINES;
                end else begin
                    score_nxt = sum_vec;
                end
            end
            OVER: begin
                if (start) begin
                    state_nxt    = RUN;
                    score_nxt    = '0;
                    new_high_nxt = 1'b0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            score    <= '0;
            high     <= '0;
            new_high <= 1'b0;
        end else begin
            state    <= state_nxt;
            score    <= score_nxt;
            high     <= high_nxt;
            new_high <= new_high_nxt;
        end
    end

    assign running   = (state == RUN);
    assign saturated = (score == ALL_NINES);
    assign shown     = show_high ? high : score;

    for (genvar g = 0; g < DIGITS; g++) begin : g_disp
        assign digits[DIGIT_W*g +: DIGIT_W] = DIGIT_W'(shown[4*g +: 4]);
    end

    always_comb begin
        logic zero_above;
        blank      = '0;
        zero_above = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_above = zero_above && (shown[4*i +: 4] == 4'd0);
            blank[i]   = zero_above;
        end
    end

endmodule

// File: tb/tb_score_bcd_counter.sv
// Scoreboard bench: stimulus pushes expected display/status per step, a
// negedge monitor pops and compares against the two DUT instances.
module tb_score_bcd_counter;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    // instance A: DIGITS=6, COIN_VALUE=5
    logic a_start = 0, a_tick = 0, a_coin = 0, a_go = 0, a_show = 0;
    logic [29:0] a_digits;
    logic [5:0]  a_blank;
    logic        a_running, a_sat, a_nh;

    // instance B: DIGITS=3, COIN_VALUE=5 (saturation reachable quickly)
    logic b_start = 0, b_tick = 0, b_coin = 0, b_go = 0, b_show = 0;
    logic [14:0] b_digits;
    logic [2:0]  b_blank;
    logic        b_running, b_sat, b_nh;

    score_bcd_counter #(.DIGITS(6), .COIN_VALUE(5)) dut_a (
        .clk(clk), .reset_n(reset_n), .start(a_start), .tick(a_tick), .coin(a_coin),
        .game_over(a_go), .show_high(a_show), .digits(a_digits), .blank(a_blank),
        .running(a_running), .saturated(a_sat), .new_high(a_nh));

    score_bcd_counter #(.DIGITS(3), .COIN_VALUE(5)) dut_b (
        .clk(clk), .reset_n(reset_n), .start(b_start), .tick(b_tick), .coin(b_coin),
        .game_over(b_go), .show_high(b_show), .digits(b_digits), .blank(b_blank),
        .running(b_running), .saturated(b_sat), .new_high(b_nh));

    typedef struct packed {
        logic        dut;
        logic [29:0] digits;
        logic [5:0]  blank;
        logic        running;
        logic        saturated;
        logic        new_high;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    total = 0;
    int    passed = 0;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t        e;
            string       nm;
            logic [29:0] dg;
            logic [5:0]  bl;
            logic        rn, st, nh;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            dg = e.dut ? {15'b0, b_digits} : a_digits;
            bl = e.dut ? {3'b0, b_blank} : a_blank;
            rn = e.dut ? b_running : a_running;
            st = e.dut ? b_sat : a_sat;
            nh = e.dut ? b_nh : a_nh;
            total++;
            if (dg === e.digits && bl === e.blank && rn === e.running &&
                st === e.saturated && nh === e.new_high)
                passed++;
            else
                $display("FAIL %s: got digits=%h blank=%b run=%b sat=%b nh=%b, want digits=%h blank=%b run=%b sat=%b nh=%b",
                         nm, dg, bl, rn, st, nh, e.digits, e.blank, e.running, e.saturated, e.new_high);
        end
    end

    task automatic drain(input string nm);
        int n = 0;
        while (exp_q.size() > 0 && n < 8) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (exp_q.size() > 0) begin
            total++;
            $display("FAIL %s: monitor did not consume expectation within 8 cycles", nm);
            exp_q.delete();
            name_q.delete();
        end
    endtask

    // val is the decimal number expected on the display
    task automatic expect_state(input bit dut, input string nm, input int val,
                                input bit run, input bit sat, input bit nh);
        exp_t e;
        int   n = dut ? 3 : 6;
        int   p = 1;
        e = '0;
        e.dut = dut;
        for (int i = 0; i < n; i++) begin
            e.digits[5*i +: 5] = 5'((val / p) % 10);
            if (i >= 1) e.blank[i] = (val < p);
            p = p * 10;
        end
        e.running   = run;
        e.saturated = sat;
        e.new_high  = nh;
        exp_q.push_back(e);
        name_q.push_back(nm);
        drain(nm);
    endtask

    task automatic pulse(input bit dut, input bit st, input bit tk, input bit cn, input bit go);
        if (dut) begin b_start = st; b_tick = tk; b_coin = cn; b_go = go; end
        else     begin a_start = st; a_tick = tk; a_coin = cn; a_go = go; end
        @(posedge clk);
        #1;
        a_start = 0; a_tick = 0; a_coin = 0; a_go = 0;
        b_start = 0; b_tick = 0; b_coin = 0; b_go = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        expect_state(0, "reset_a", 0, 0, 0, 0);
        expect_state(1, "reset_b", 0, 0, 0, 0);
        @(negedge clk); #1;
        reset_n = 1'b1;

        pulse(0, 0, 1, 1, 1);
        expect_state(0, "idle_ignores", 0, 0, 0, 0);
        pulse(0, 1, 0, 0, 0);
        expect_state(0, "start_run", 0, 1, 0, 0);
        repeat (12) pulse(0, 0, 1, 0, 0);
        expect_state(0, "ticks_12", 12, 1, 0, 0);

        pulse(0, 1, 1, 0, 0);
        expect_state(0, "restart_run", 0, 1, 0, 0);
        repeat (8) pulse(0, 0, 1, 0, 0);
        expect_state(0, "ticks_8", 8, 1, 0, 0);
        pulse(0, 0, 1, 1, 0);
        expect_state(0, "tick_coin_14", 14, 1, 0, 0);
        repeat (197) pulse(0, 0, 0, 1, 0);
        expect_state(0, "coins_999", 999, 1, 0, 0);
        pulse(0, 0, 1, 0, 0);
        expect_state(0, "ripple_1000", 1000, 1, 0, 0);

        pulse(0, 1, 0, 0, 0);
        repeat (24) pulse(0, 0, 0, 1, 0);
        expect_state(0, "score_120", 120, 1, 0, 0);
        pulse(0, 0, 0, 0, 1);
        expect_state(0, "over_120", 120, 0, 0, 1);
        a_show = 1;
        expect_state(0, "high_120", 120, 0, 0, 1);
        a_show = 0;
        pulse(0, 0, 1, 1, 0);
        expect_state(0, "over_frozen", 120, 0, 0, 1);
        pulse(0, 1, 0, 0, 0);
        expect_state(0, "start_clr_nh", 0, 1, 0, 0);
        repeat (10) pulse(0, 0, 0, 1, 0);
        pulse(0, 0, 0, 0, 1);
        expect_state(0, "over_50", 50, 0, 0, 0);
        a_show = 1;
        expect_state(0, "high_kept_120", 120, 0, 0, 0);
        a_show = 0;
        expect_state(0, "show_score_50", 50, 0, 0, 0);

        pulse(0, 1, 0, 0, 0);
        repeat (3) pulse(0, 0, 1, 0, 0);
        expect_state(0, "run_3", 3, 1, 0, 0);
        @(posedge clk); #2;
        reset_n = 1'b0;
        expect_state(0, "async_reset", 0, 0, 0, 0);
        a_show = 1;
        expect_state(0, "reset_high_clr", 0, 0, 0, 0);
        a_show = 0;
        reset_n = 1'b1;

        pulse(0, 1, 0, 0, 0);
        repeat (7) pulse(0, 0, 1, 0, 0);
        pulse(0, 0, 1, 0, 1);
        expect_state(0, "go_tick_score7", 7, 0, 0, 1);
        a_show = 1;
        expect_state(0, "go_tick_high7", 7, 0, 0, 1);
        a_show = 0;
        pulse(0, 0, 1, 0, 0);
        expect_state(0, "over_tick_ign", 7, 0, 0, 1);
        pulse(0, 1, 0, 0, 0);
        repeat (3) pulse(0, 0, 1, 0, 0);
        pulse(0, 1, 0, 0, 1);
        expect_state(0, "start_beats_go", 0, 1, 0, 0);
        a_show = 1;
        expect_state(0, "start_go_high7", 7, 1, 0, 0);
        a_show = 0;

        pulse(1, 1, 0, 0, 0);
        repeat (199) pulse(1, 0, 0, 1, 0);
        expect_state(1, "b_995", 995, 1, 0, 0);
        pulse(1, 0, 0, 1, 0);
        expect_state(1, "b_sat_999", 999, 1, 1, 0);
        pulse(1, 0, 1, 0, 0);
        expect_state(1, "b_sat_tick", 999, 1, 1, 0);
        pulse(1, 0, 1, 1, 0);
        expect_state(1, "b_sat_both", 999, 1, 1, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
